// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state codes and default latencies.
package muldiv_unit_pkg;

   // Operation selector driven by the execute stage
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Latches operands on a
// start pulse, holds busy for the operation latency, then commits HI/LO.
// MTHI/MTLO write directly while idle; MFHI/MFLO read combinationally.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDOp,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   output logic        busy,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   md_state_e        r_state;
   md_state_e        w_state_next;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_op_a;
   logic [31:0]      r_op_b;
   logic             r_signed;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   md_op_e           w_op;
   logic             w_start_mul;
   logic             w_start_div;
   logic             w_idle;
   logic             w_commit;

   logic [63:0]      w_ext_a;
   logic [63:0]      w_ext_b;
   logic [63:0]      w_prod;
   logic             w_neg_a;
   logic             w_neg_b;
   logic             w_div_zero;
   logic [31:0]      w_mag_a;
   logic [31:0]      w_mag_b;
   logic [31:0]      w_mag_q;
   logic [31:0]      w_mag_r;
   logic [31:0]      w_quot;
   logic [31:0]      w_rem;

   assign w_op        = md_op_e'(MDOp);
   assign w_start_mul = start && ((w_op == MD_MULT) || (w_op == MD_MULTU));
   assign w_start_div = start && ((w_op == MD_DIV)  || (w_op == MD_DIVU));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic: leave IDLE on a legal start, return after the last busy cycle
   always_comb begin
      // NOTE: default first so no path leaves the signal unassigned and a latch cannot be inferred.
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_mul)      w_state_next = ST_MUL;
            else if (w_start_div) w_state_next = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (r_count == '0) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: busy whenever not idle, commit on the final busy edge
   always_comb begin
      w_idle   = (r_state == ST_IDLE);
      w_commit = !w_idle && (r_count == '0);
   end

   assign busy = !w_idle;

   // Down-counter: loaded with N-1 on entry, counts to zero while busy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (w_idle) begin
         if (w_start_mul)      r_count <= CNT_W'(MULT_CYCLES - 1);
         else if (w_start_div) r_count <= CNT_W'(DIV_CYCLES - 1);
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // Operand latch: captured only at an accepted start, so D1/D2 are free while busy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_signed <= 1'b0;
      end else if (w_idle && (w_start_mul || w_start_div)) begin
         r_op_a   <= D1;
         r_op_b   <= D2;
         r_signed <= (w_op == MD_MULT) || (w_op == MD_DIV);
      end
   end

   // Arithmetic from latched operands; one 64-bit multiplier serves both signednesses
   // because the low 64 bits of a sign-extended product equal the two's-complement product.
   // Division works on magnitudes and restores signs, which also yields
   // 0x80000000 / -1 = 0x80000000 with zero remainder without a special case.
   always_comb begin
      w_ext_a    = r_signed ? {{32{r_op_a[31]}}, r_op_a} : {32'd0, r_op_a};
      w_ext_b    = r_signed ? {{32{r_op_b[31]}}, r_op_b} : {32'd0, r_op_b};
      w_prod     = w_ext_a * w_ext_b;
      w_neg_a    = r_signed && r_op_a[31];
      w_neg_b    = r_signed && r_op_b[31];
      w_mag_a    = w_neg_a ? (32'd0 - r_op_a) : r_op_a;
      w_mag_b    = w_neg_b ? (32'd0 - r_op_b) : r_op_b;
      w_div_zero = (r_op_b == '0);
      w_mag_q    = w_div_zero ? '0 : (w_mag_a / w_mag_b);
      w_mag_r    = w_div_zero ? '0 : (w_mag_a % w_mag_b);
      w_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
      w_rem      = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;
   end

   // HI/LO: commit results at end of operation, or direct moves while idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         if (r_state == ST_MUL) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end else if (!w_div_zero) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
         end
      end else if (w_idle) begin
         if (w_op == MD_MTHI) r_hi <= D1;
         if (w_op == MD_MTLO) r_lo <= D1;
      end
   end

   // Read path into the execute-stage result mux
   always_comb begin
      result = '0;
      case (w_op)
         MD_MFHI: result = r_hi;
         MD_MFLO: result = r_lo;
         default: result = '0;
      endcase
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference of HI/LO.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  MDOp;
   logic [31:0] D1;
   logic [31:0] D2;
   logic        busy;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;

   muldiv_unit #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .MDOp   (MDOp),
      .D1     (D1),
      .D2     (D2),
      .busy   (busy),
      .result (result),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so the bench can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: architectural HI/LO after an operation, from plain 64-bit arithmetic
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT: begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         MD_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         MD_DIV: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
         end
         MD_DIVU: if (b != 0) begin
            m_lo = a / b;
            m_hi = a % b;
         end
         default: ;
      endcase
   endfunction

   // Issue one mult/div, count busy cycles, then compare HI/LO and the read path.
   // inject: 0 none, 1 second start while busy, 2 MTLO while busy.
   task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject, input string tag);
      int cycles;
      int exp_n;
      cycles = 0;
      exp_n  = ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_N : DIV_N;
      @(negedge clk);
      start = 1'b1; MDOp = op; D1 = a; D2 = b;
      ref_op(op, a, b);
      @(negedge clk);
      start = 1'b0; MDOp = MD_NONE; D1 = $urandom; D2 = $urandom;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         if (cycles == 2 && inject == 1) begin
            start = 1'b1; MDOp = MD_DIVU; D1 = $urandom; D2 = 32'd3;
         end else if (cycles == 2 && inject == 2) begin
            MDOp = MD_MTLO; D1 = 32'hDEAD_0001;
         end else begin
            start = 1'b0; MDOp = MD_NONE;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " busy cycles"}, 32'(cycles), 32'(exp_n));
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
      MDOp = MD_MFHI;
      #1 check({tag, " mfhi"}, result, m_hi);
      MDOp = MD_MFLO;
      #1 check({tag, " mflo"}, result, m_lo);
      MDOp = MD_NONE;
      #1 check({tag, " result idle"}, result, 32'd0);
   endtask

   // MTHI/MTLO then read back through MFHI/MFLO on the next cycle
   task automatic mt(input logic sel_hi, input logic [31:0] v, input string tag);
      @(negedge clk);
      MDOp = sel_hi ? MD_MTHI : MD_MTLO; D1 = v;
      @(negedge clk);
      MDOp = sel_hi ? MD_MFHI : MD_MFLO; D1 = $urandom;
      if (sel_hi) m_hi = v;
      else        m_lo = v;
      #1 check({tag, " readback"}, result, v);
      MDOp = MD_NONE;
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      reset = 1'b0; start = 1'b0; MDOp = MD_MFHI; D1 = '0; D2 = '0;
      #3;
      check("reset busy", 32'(busy), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      reset = 1'b1; MDOp = MD_NONE;

      // Directed arithmetic cases
      run_md(MD_MULT, 32'd3, 32'hFFFF_FFFE, 0, "mult 3*-2");
      check("mult 3*-2 hi const", hi, 32'hFFFF_FFFF);
      check("mult 3*-2 lo const", lo, 32'hFFFF_FFFA);
      run_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu");
      check("multu hi const", hi, 32'h0000_0001);
      check("multu lo const", lo, 32'hFFFF_FFFE);
      run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
      check("div -7/2 lo const", lo, 32'hFFFF_FFFD);
      check("div -7/2 hi const", hi, 32'hFFFF_FFFF);
      run_md(MD_DIVU, 32'd7, 32'd2, 0, "divu 7/2");
      check("divu lo const", lo, 32'd3);
      check("divu hi const", hi, 32'd1);

      // Divide by zero leaves HI/LO alone
      mt(1'b1, 32'h11, "mthi 0x11");
      mt(1'b0, 32'h22, "mtlo 0x22");
      run_md(MD_DIV, 32'h1234, 32'd0, 0, "div by 0");
      check("div by 0 hi const", hi, 32'h11);
      check("div by 0 lo const", lo, 32'h22);

      // Overflow case without trap
      run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
      check("div ovf lo const", lo, 32'h8000_0000);
      check("div ovf hi const", hi, 32'd0);

      mt(1'b1, 32'hABCD, "mthi 0xabcd");

      // Illegal traffic while busy
      run_md(MD_MULTU, 32'h10, 32'h10, 2, "mtlo during busy");
      check("mtlo during busy lo const", lo, 32'h100);
      run_md(MD_MULT, 32'd7, 32'd9, 1, "start during busy");
      check("start during busy lo const", lo, 32'd63);

      // Start with non-arithmetic codes does nothing
      @(negedge clk);
      start = 1'b1; MDOp = MD_NONE; D1 = $urandom; D2 = $urandom;
      @(negedge clk);
      MDOp = MD_MFLO;
      @(negedge clk);
      MDOp = 4'd12;
      @(negedge clk);
      start = 1'b0; MDOp = MD_NONE;
      #1;
      check("bad start busy", 32'(busy), 32'd0);
      check("bad start hi", hi, m_hi);
      check("bad start lo", lo, m_lo);

      // Random operations against the reference
      for (int i = 0; i < 16; i++) begin
         rop = 4'($urandom_range(1, 4));
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: rb = $urandom;
         endcase
         run_md(rop, ra, rb, 0, $sformatf("rand%0d op%0d", i, rop));
      end

      // Reset in the third busy cycle of a multiply
      mt(1'b1, 32'h55, "mthi 0x55");
      @(negedge clk);
      start = 1'b1; MDOp = MD_MULT; D1 = 32'd5; D2 = 32'd6;
      @(negedge clk);
      start = 1'b0; MDOp = MD_NONE;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset hi", hi, 32'd0);
      check("mid reset lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("after reset busy", 32'(busy), 32'd0);
      check("after reset hi", hi, 32'd0);
      run_md(MD_MULT, 32'd5, 32'd6, 0, "post reset mult");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
